// File: rtl/ir_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ir_cmd_queue                                               |
// | Description : Conditions raw IR key codes into a legal snake direction   |
// |               queue, popped on move ticks, plus a start pulse.           |
// |               Optional repeat suppression: define IR_CMD_HOLDOFF_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ir_cmd_queue #(
    parameter int         DEPTH     = 4,
    parameter int         HOLDOFF   = 2_500_000,
    parameter logic [7:0] KEY_UP    = 8'h18,
    parameter logic [7:0] KEY_DOWN  = 8'h52,
    parameter logic [7:0] KEY_LEFT  = 8'h08,
    parameter logic [7:0] KEY_RIGHT = 8'h5A,
    parameter logic [7:0] KEY_START = 8'h1C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir_data,
    input  logic       ir_dout_vld,
    input  logic       play_en,
    input  logic       move_tick,
    output logic [1:0] dir,
    output logic       dir_upd,
    output logic       start_pulse,
    output logic [3:0] q_level,
    output logic [7:0] drop_cnt
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    logic [1:0]         r_fifo [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic [1:0]         r_dir;
    logic               r_dir_upd;
    logic               r_start_pulse;
    logic [7:0]         r_drop_cnt;

    logic               w_vld;
    logic               w_is_dir;
    logic [1:0]         w_code;
    logic [1:0]         w_ref;
    logic [c_ptr_w-1:0] w_tail_ptr;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_start;

`ifdef IR_CMD_HOLDOFF_EN
    localparam int c_tmr_w = $clog2(HOLDOFF + 1);

    logic [c_tmr_w-1:0] r_tmr;
    logic [7:0]         r_last_code;

    // A repeat is suppressed only while the window since the previous strobe is still open
    assign w_vld = ir_dout_vld && !((ir_data == r_last_code) && (r_tmr != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr       <= '0;
            r_last_code <= 8'h00;
        end else if (ir_dout_vld) begin
            r_tmr       <= c_tmr_w'(HOLDOFF);
            r_last_code <= ir_data;
        end else if (r_tmr != '0) begin
            r_tmr <= r_tmr - c_tmr_w'(1);
        end
    end
`else
    logic w_unused_holdoff;

    assign w_vld            = ir_dout_vld;
    assign w_unused_holdoff = (HOLDOFF != 0);
`endif

    always_comb begin
        w_is_dir = 1'b1;
        w_code   = 2'b00;
        if (ir_data == KEY_UP)         w_code = 2'b00;
        else if (ir_data == KEY_DOWN)  w_code = 2'b01;
        else if (ir_data == KEY_LEFT)  w_code = 2'b10;
        else if (ir_data == KEY_RIGHT) w_code = 2'b11;
        else                           w_is_dir = 1'b0;
    end

    assign w_tail_ptr = r_wr_ptr - c_ptr_w'(1);
    assign w_ref      = (r_level != '0) ? r_fifo[w_tail_ptr] : r_dir;
    assign w_full     = (r_level == c_lvl_w'(DEPTH));
    assign w_pop      = move_tick && play_en && (r_level != '0);

    // Reverse pairs differ only in the LSB of the direction encoding
    assign w_push  = w_vld && w_is_dir && play_en &&
                     (w_code != w_ref) && (w_code != (w_ref ^ 2'b01)) &&
                     (!w_full || w_pop);
    assign w_drop  = w_vld && w_is_dir && play_en && !w_push;
    assign w_start = w_vld && (ir_data == KEY_START);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_dir         <= 2'b11;
            r_dir_upd     <= 1'b0;
            r_start_pulse <= 1'b0;
            r_drop_cnt    <= 8'h00;
        end else begin
            r_dir_upd     <= w_pop;
            r_start_pulse <= w_start;
            if (w_pop) begin
                r_dir <= r_fifo[r_rd_ptr];
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            // Leaving play or restarting discards any queued turns
            if (w_start || !play_en) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                if (w_push && !w_pop)      r_level <= r_level + c_lvl_w'(1);
                else if (w_pop && !w_push) r_level <= r_level - c_lvl_w'(1);
            end
        end
    end

    assign dir         = r_dir;
    assign dir_upd     = r_dir_upd;
    assign start_pulse = r_start_pulse;
    assign q_level     = 4'(r_level);
    assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ir_cmd_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ir_cmd_queue                                            |
// | Description : Self-checking bench for ir_cmd_queue with a queue model.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ir_cmd_queue;
    localparam int         DEPTH     = 4;
    localparam int         HOLDOFF   = 40;
    localparam logic [7:0] K_UP      = 8'h18;
    localparam logic [7:0] K_DOWN    = 8'h52;
    localparam logic [7:0] K_LEFT    = 8'h08;
    localparam logic [7:0] K_RIGHT   = 8'h5A;
    localparam logic [7:0] K_START   = 8'h1C;

    logic       clk;
    logic       rst;
    logic [7:0] ir_data;
    logic       ir_dout_vld;
    logic       play_en;
    logic       move_tick;
    logic [1:0] dir;
    logic       dir_upd;
    logic       start_pulse;
    logic [3:0] q_level;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] m_q[$];
    logic [1:0] m_dir;
    int         m_drop;
    bit         m_upd;
    bit         m_start;
    logic [7:0] m_last;
    longint     m_last_t;
    longint     cyc;

    ir_cmd_queue #(
        .DEPTH(DEPTH), .HOLDOFF(HOLDOFF),
        .KEY_UP(K_UP), .KEY_DOWN(K_DOWN), .KEY_LEFT(K_LEFT),
        .KEY_RIGHT(K_RIGHT), .KEY_START(K_START)
    ) dut (
        .clk(clk), .rst(rst), .ir_data(ir_data), .ir_dout_vld(ir_dout_vld),
        .play_en(play_en), .move_tick(move_tick), .dir(dir), .dir_upd(dir_upd),
        .start_pulse(start_pulse), .q_level(q_level), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int key_to_dir(input logic [7:0] k);
        if (k == K_UP)    return 0;
        if (k == K_DOWN)  return 1;
        if (k == K_LEFT)  return 2;
        if (k == K_RIGHT) return 3;
        return -1;
    endfunction

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the clock, update the model, settle outputs
    task automatic step(input bit r, input bit vld, input logic [7:0] code,
                        input bit play, input bit tick);
        bit         accept;
        bit         pop;
        bit         push;
        int         d;
        logic [1:0] refd;
        rst = r; ir_dout_vld = vld; ir_data = code; play_en = play; move_tick = tick;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_q.delete();
            m_dir = 2'b11; m_drop = 0; m_upd = 0; m_start = 0;
            m_last = 8'h00; m_last_t = -1_000_000;
        end else begin
            accept = vld;
`ifdef IR_CMD_HOLDOFF_EN
            if (vld) begin
                if (code == m_last && (cyc - m_last_t) <= HOLDOFF) accept = 0;
                m_last = code; m_last_t = cyc;
            end
`endif
            d     = accept ? key_to_dir(code) : -1;
            refd  = (m_q.size() > 0) ? m_q[$] : m_dir;
            pop   = tick && play && (m_q.size() > 0);
            push  = 0;
            m_upd = pop;
            m_start = accept && (code == K_START);
            if (d >= 0 && play) begin
                if (2'(d) != refd && 2'(d) != opposite(refd) && (m_q.size() < DEPTH || pop))
                    push = 1;
                else if (m_drop < 255)
                    m_drop++;
            end
            if (pop)  m_dir = m_q.pop_front();
            if (push) m_q.push_back(2'(d));
            if (m_start || !play) m_q.delete();
        end
        #1;
        ir_dout_vld = 0; move_tick = 0;
    endtask

    task automatic test_reset;
        step(1, 1, K_UP, 1, 1);
        checks++; if (dir !== 2'b11) begin errors++; $display("FAIL reset_dir actual=%b required=11", dir); end
        checks++; if (q_level !== 4'd0) begin errors++; $display("FAIL reset_level actual=%0d required=0", q_level); end
        checks++; if (drop_cnt !== 8'd0 || dir_upd !== 1'b0 || start_pulse !== 1'b0) begin
            errors++; $display("FAIL reset_flags actual drop=%0d upd=%b start=%b required 0/0/0", drop_cnt, dir_upd, start_pulse); end
        step(0, 0, 8'h00, 1, 1);
        checks++; if (dir !== 2'b11 || dir_upd !== 1'b0 || q_level !== 4'd0) begin
            errors++; $display("FAIL empty_tick actual dir=%b upd=%b lvl=%0d required 11/0/0", dir, dir_upd, q_level); end
    endtask

    task automatic test_two_pushes;
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        step(0, 1, K_LEFT, 1, 0);
        checks++; if (q_level !== 4'd2) begin errors++; $display("FAIL two_level actual=%0d required=2", q_level); end
        step(0, 0, 8'h00, 1, 1);
        checks++; if (dir !== 2'b00 || dir_upd !== 1'b1 || q_level !== 4'd1) begin
            errors++; $display("FAIL pop1 actual dir=%b upd=%b lvl=%0d required 00/1/1", dir, dir_upd, q_level); end
        step(0, 0, 8'h00, 1, 0);
        checks++; if (dir_upd !== 1'b0) begin errors++; $display("FAIL upd_width actual=%b required=0", dir_upd); end
        step(0, 0, 8'h00, 1, 1);
        checks++; if (dir !== 2'b10 || dir_upd !== 1'b1 || q_level !== 4'd0) begin
            errors++; $display("FAIL pop2 actual dir=%b upd=%b lvl=%0d required 10/1/0", dir, dir_upd, q_level); end
    endtask

    task automatic test_reverse;
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, K_LEFT, 1, 0);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd0) begin
            errors++; $display("FAIL reverse_drop actual drop=%0d lvl=%0d required 1/0", drop_cnt, q_level); end
        step(0, 1, K_UP, 1, 0);
        step(0, 1, K_RIGHT, 1, 0);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd2) begin
            errors++; $display("FAIL reverse_tail actual drop=%0d lvl=%0d required 1/2", drop_cnt, q_level); end
        step(0, 1, K_LEFT, 0, 0);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd0) begin
            errors++; $display("FAIL idle_press actual drop=%0d lvl=%0d required 1/0", drop_cnt, q_level); end
    endtask

    task automatic test_full;
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        step(0, 1, K_LEFT, 1, 0);
        step(0, 1, K_DOWN, 1, 0);
        step(0, 1, K_RIGHT, 1, 0);
        checks++; if (q_level !== 4'd4) begin errors++; $display("FAIL fill_level actual=%0d required=4", q_level); end
        step(0, 1, K_DOWN, 1, 0);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd4) begin
            errors++; $display("FAIL full_drop actual drop=%0d lvl=%0d required 1/4", drop_cnt, q_level); end
        step(0, 1, K_UP, 1, 1);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd4 || dir !== 2'b00 || dir_upd !== 1'b1) begin
            errors++; $display("FAIL full_push_pop actual drop=%0d lvl=%0d dir=%b upd=%b required 1/4/00/1",
                               drop_cnt, q_level, dir, dir_upd); end
    endtask

    task automatic test_start;
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        step(0, 1, K_LEFT, 1, 0);
        step(0, 1, K_DOWN, 1, 0);
        step(0, 1, K_START, 1, 0);
        checks++; if (start_pulse !== 1'b1 || q_level !== 4'd0 || dir !== 2'b11) begin
            errors++; $display("FAIL start_flush actual sp=%b lvl=%0d dir=%b required 1/0/11", start_pulse, q_level, dir); end
        step(0, 0, 8'h00, 1, 0);
        checks++; if (start_pulse !== 1'b0) begin errors++; $display("FAIL start_width actual=%b required=0", start_pulse); end
        step(1, 0, 8'h00, 0, 0);
        step(0, 1, K_START, 0, 0);
        checks++; if (start_pulse !== 1'b1) begin errors++; $display("FAIL start_idle actual=%b required=1", start_pulse); end
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h77, 1, 0);
        checks++; if (start_pulse !== 1'b0 || drop_cnt !== 8'd0 || q_level !== 4'd0) begin
            errors++; $display("FAIL other_key actual sp=%b drop=%0d lvl=%0d required 0/0/0", start_pulse, drop_cnt, q_level); end
    endtask

`ifdef IR_CMD_HOLDOFF_EN
    task automatic test_holdoff;
        step(1, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        for (int i = 0; i < HOLDOFF - 1; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        checks++; if (drop_cnt !== 8'd0 || q_level !== 4'd1) begin
            errors++; $display("FAIL holdoff_repeat actual drop=%0d lvl=%0d required 0/1", drop_cnt, q_level); end
        for (int i = 0; i < HOLDOFF; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 1, K_UP, 1, 0);
        checks++; if (drop_cnt !== 8'd1 || q_level !== 4'd1) begin
            errors++; $display("FAIL holdoff_expired actual drop=%0d lvl=%0d required 1/1", drop_cnt, q_level); end
    endtask
`endif

    task automatic test_random;
        logic [7:0] keys [6];
        keys[0] = K_UP; keys[1] = K_DOWN; keys[2] = K_LEFT;
        keys[3] = K_RIGHT; keys[4] = K_START; keys[5] = 8'hA5;
        step(1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
                 keys[$urandom_range(0, 5)], ($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 9) < 3));
            checks++;
            if (dir !== m_dir || dir_upd !== m_upd || start_pulse !== m_start ||
                q_level !== 4'(m_q.size()) || drop_cnt !== 8'(m_drop)) begin
                errors++;
                $display("FAIL random_cycle%0d actual dir=%b upd=%b sp=%b lvl=%0d drop=%0d required dir=%b upd=%b sp=%b lvl=%0d drop=%0d",
                         i, dir, dir_upd, start_pulse, q_level, drop_cnt,
                         m_dir, m_upd, m_start, m_q.size(), m_drop);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ir_data = 8'h00; ir_dout_vld = 1'b0; play_en = 1'b0; move_tick = 1'b0;
        cyc = 0;
        #1;
        test_reset;
        test_two_pushes;
        test_reverse;
        test_full;
        test_start;
`ifdef IR_CMD_HOLDOFF_EN
        test_holdoff;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_cmd_queue.md
# ir_cmd_queue

Command-conditioning stage between the IR decoder and the snake controller. Consumes raw NEC key codes (`ir_data` / `ir_dout_vld`) and produces a legal movement direction that changes only on snake step boundaries, plus a one-cycle start pulse. Direction presses are buffered in a small FIFO so quick key sequences (e.g. UP then LEFT within one step) are applied on successive steps. Reversals, duplicates and auto-repeat frames are dropped.

## Interface
- `DEPTH`, 4: direction FIFO depth, power of two, 2..8.
- `HOLDOFF`, 2_500_000: repeat-suppression window in clk cycles (100 ms at 25 MHz).
- `KEY_UP`, 8'h18: up key code.
- `KEY_DOWN`, 8'h52: down key code.
- `KEY_LEFT`, 8'h08: left key code.
- `KEY_RIGHT`, 8'h5A: right key code.
- `KEY_START`, 8'h1C: start/restart key code.

Ports:
- `clk`  in  1: system clock (25 MHz domain).
- `rst`  in  1: reset, synchronous, active-high.
- `ir_data`  in  8: decoded key code, valid with `ir_dout_vld`.
- `ir_dout_vld`  in  1: one-cycle strobe from the IR decoder.
- `play_en`  in  1: high while the game is in the play state.
- `move_tick`  in  1: one-cycle pulse, the snake advances one cell.
- `dir`  out  2: current direction. 00 up, 01 down, 10 left, 11 right.
- `dir_upd`  out  1: one-cycle pulse when `dir` has just been loaded from the FIFO.
- `start_pulse`  out  1: one-cycle pulse on an accepted start key.
- `q_level`  out  4: FIFO occupancy, 0..DEPTH.
- `drop_cnt`  out  8: count of rejected direction presses, saturating at 255.

## Operation
- Reset values: `dir`=11 (right), `dir_upd`=0, `start_pulse`=0, `q_level`=0, `drop_cnt`=0, FIFO pointers 0, holdoff timer expired, last-code register 8'h00.
- Classification on `ir_dout_vld`: the code is a direction key, `KEY_START`, or other. Other codes are ignored and not counted.
- Reference direction `ref`: the FIFO tail entry if `q_level`>0, otherwise `dir`.
- A direction press is accepted and pushed when all of these hold: `play_en`=1; code ≠ `ref`; code is not the reverse of `ref` (up/down and left/right are reverse pairs); and the FIFO is not full, or a pop occurs in the same cycle.
- A direction press that fails any of these checks is dropped and increments `drop_cnt`, except presses made while `play_en`=0, which are dropped silently.
- Start key: `start_pulse` asserts and the FIFO is flushed (`q_level`→0). `dir` is unchanged; `snake_ctrl` owns the restart position. The start key is accepted regardless of `play_en`.
- Pop: on `move_tick` with `play_en`=1 and `q_level`>0, the head entry is loaded into `dir` and `dir_upd` pulses.
  - Empty FIFO on a tick: no change, no `dir_upd`.
- Simultaneous push and pop: both take effect and `q_level` is unchanged. With a full FIFO, the push succeeds because the pop frees a slot.
- Push/pop order for `ref`: push legality is evaluated against the pre-pop state.
- `play_en` falling edge: the FIFO is flushed on the next cycle, and `move_tick` is ignored while `play_en`=0.
- Reset mid-operation: all state returns to reset values on the next edge. A strobe in the same cycle as reset is discarded.
- Pointers wrap modulo DEPTH. `q_level` is a separate counter, width clog2(DEPTH)+1, with no wrap.

## Timing
- `ir_dout_vld` at cycle N → `q_level`, `drop_cnt` and `start_pulse` update at N+1.
- `move_tick` at cycle T → `dir` and `dir_upd` at T+1. `dir_upd` is high for exactly one cycle.
- A press at N followed by a tick at N+1 is poppable, giving `dir` at N+2. A press and a tick in the same cycle N: the tick pops the older entry only (or nothing if the FIFO was empty).
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- `IR_CMD_HOLDOFF_EN` defined: a code identical to the last received code that arrives within HOLDOFF cycles of it is discarded before classification, not counted and not pushed.
  - Every strobe restarts the timer and updates the last code.
  - A different code is never held off.
- `IR_CMD_HOLDOFF_EN` undefined: the timer and last-code register are not built, and every strobe is classified.

## Test plan
- Reset then tick with the FIFO empty → `dir`=11, no `dir_upd`, `q_level`=0.
- Push UP then LEFT (play_en=1), then two ticks → `dir`=00 at the first tick+1, then `dir`=10 at the second tick+1, each with a one-cycle `dir_upd`; `q_level` goes 2→1→0.
- With `dir`=11, press LEFT, then press RIGHT after an UP is queued → LEFT is dropped as a reverse; RIGHT pushes (reverse check is against the UP tail). `drop_cnt`=1.
- Fill to DEPTH=4 (UP, LEFT, DOWN, RIGHT). A fifth press alone → dropped, `drop_cnt`+1. A fifth press coinciding with a tick → accepted, `q_level` stays 4.
- Queue 3 entries, then press START → `start_pulse` at N+1, `q_level`=0, `dir` unchanged. Press START with `play_en`=0 → still pulses.
- With IR_CMD_HOLDOFF_EN: UP twice 1000 cycles apart → second is ignored with no drop counted; UP again HOLDOFF+1 cycles after the last strobe → classified (dropped as equal to `ref`, `drop_cnt`+1).
